// File: rtl/sync_ff.sv
// N-stage flip-flop synchronizer with synchronous active-low reset to 0.
// N = 0 collapses to a plain wire so a synchronous source can skip the latency.
module sync_ff #(
  parameter int N = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  if (N == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign q_o = d_i;
  end else begin : g_chain
    logic [N-1:0] sync_q;

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= d_i;
        for (int i = 1; i < N; i++) begin
          sync_q[i] <= sync_q[i-1];
        end
      end
    end

    assign q_o = sync_q[N-1];
  end

endmodule

// File: rtl/debounce.sv
// Single-bit debouncer: o_switch takes the synchronized input only after it has
// disagreed with o_switch for DEBOUNCE_TIME consecutive cycles.
module debounce #(
  parameter int DEBOUNCE_TIME = 2,
  parameter int SYNC_STAGES   = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_switch,
  output logic o_switch
);

  if (DEBOUNCE_TIME < 1) begin : g_bad_time
    $error("debounce: DEBOUNCE_TIME must be at least 1");
  end
  if (SYNC_STAGES < 0 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("debounce: SYNC_STAGES must be in 0..4");
  end

  localparam int CNT_W_RAW = $clog2(longint'(DEBOUNCE_TIME) + 64'd1);
  localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TIME - 1);

  logic             s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;

  sync_ff #(
    .N (SYNC_STAGES)
  ) u_sync (
    .clk_i  (i_clk),
    .rst_ni (i_reset),
    .d_i    (i_switch),
    .q_o    (s)
  );

  // Any agreement clears the count, so glitches never accumulate partial progress.
  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (s == out_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      out_d = s;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      out_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_switch = out_q;

endmodule

// File: tb/tb_debounce.sv
// Directed bench for debounce: several parameterizations share one clock and
// are exercised in a single linear sequence with hand-computed expectations.
module tb_debounce;

  logic clk;
  int   n_asserts = 0;
  int   n_fail    = 0;

  // defaults (DT=2, SS=2)
  logic rst_a, sw_a, out_a;
  // DT=5, SS=2
  logic rst_5, sw_5, out_5;
  // DT=1, SS=0
  logic rst_1, sw_1, out_1;
  // DT=8, SS=2
  logic rst_8, sw_8, out_8;
  // DT=5000, SS=2
  logic rst_k, sw_k, out_k;

  debounce dut_a (.i_clk(clk), .i_reset(rst_a), .i_switch(sw_a), .o_switch(out_a));
  debounce #(.DEBOUNCE_TIME(5), .SYNC_STAGES(2)) dut_5
    (.i_clk(clk), .i_reset(rst_5), .i_switch(sw_5), .o_switch(out_5));
  debounce #(.DEBOUNCE_TIME(1), .SYNC_STAGES(0)) dut_1
    (.i_clk(clk), .i_reset(rst_1), .i_switch(sw_1), .o_switch(out_1));
  debounce #(.DEBOUNCE_TIME(8), .SYNC_STAGES(2)) dut_8
    (.i_clk(clk), .i_reset(rst_8), .i_switch(sw_8), .o_switch(out_8));
  debounce #(.DEBOUNCE_TIME(5000), .SYNC_STAGES(2)) dut_k
    (.i_clk(clk), .i_reset(rst_k), .i_switch(sw_k), .o_switch(out_k));

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge; inputs driven afterwards land before the next edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    int   cnt_max;
    logic r;

    {rst_a, rst_5, rst_1, rst_8, rst_k} = '0;
    {sw_a, sw_5, sw_1, sw_8, sw_k}      = '0;
    tick(2);

    // ---- reset then hold (defaults) ----
    sw_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_hold_out", 32'(out_a), 0);
      check("rst_hold_cnt", 32'(dut_a.cnt_q), 0);
    end
    rst_a = 1'b1;
    rst_5 = 1'b1;
    rst_8 = 1'b1;
    rst_k = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rel_latency_low", 32'(out_a), 0);
    end
    tick();
    check("rel_latency_high", 32'(out_a), 1);

    // ---- clean edges, DT=5 SS=2: change at edge E, output at E+6 ----
    sw_5 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rise_early", 32'(out_5), 0);
    end
    tick();
    check("rise_at_e6", 32'(out_5), 1);
    tick(3);
    sw_5 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("fall_early", 32'(out_5), 1);
    end
    tick();
    check("fall_at_e6", 32'(out_5), 0);
    tick(3);

    // ---- glitch rejection, DT=5: 1x4, 0x1, 1x4 ----
    sw_5 = 1'b1; tick(4);
    sw_5 = 1'b0; tick(1);
    sw_5 = 1'b1; tick(4);
    sw_5 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("glitch_rejected", 32'(out_5), 0);
    end
    check("glitch_cnt_cleared", 32'(dut_5.cnt_q), 0);
    sw_5 = 1'b1; tick(5);
    sw_5 = 1'b0;
    tick(1);
    check("pulse5_not_yet", 32'(out_5), 0);
    tick(1);
    check("pulse5_accepted", 32'(out_5), 1);

    // ---- DT=1 SS=0: one-cycle delay of a random stream ----
    rst_1 = 1'b1;
    for (int i = 0; i < 24; i++) begin
      r    = 1'($urandom_range(0, 1));
      sw_1 = r;
      tick();
      check("dt1_delay", 32'(out_1), 32'(r));
    end

    // ---- reset mid-count, DT=8 ----
    sw_8 = 1'b1;
    tick(7);
    check("mid_count_cnt5", 32'(dut_8.cnt_q), 5);
    rst_8 = 1'b0;
    tick();
    check("mid_rst_out", 32'(out_8), 0);
    check("mid_rst_cnt", 32'(dut_8.cnt_q), 0);
    rst_8 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("mid_rst_refill", 32'(out_8), 0);
    end
    tick();
    check("mid_rst_rise", 32'(out_8), 1);

    // ---- large count, DT=5000: a 4999-cycle hold is rejected ----
    cnt_max = 0;
    sw_k = 1'b1;
    for (int i = 0; i < 4999; i++) begin
      tick();
      if (int'(dut_k.cnt_q) > cnt_max) cnt_max = int'(dut_k.cnt_q);
    end
    sw_k = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (int'(dut_k.cnt_q) > cnt_max) cnt_max = int'(dut_k.cnt_q);
    end
    check("k4999_rejected", 32'(out_k), 0);
    check("k4999_peak_cnt", 32'(cnt_max), 4999);
    check("k4999_cnt_cleared", 32'(dut_k.cnt_q), 0);

    // A 5000-cycle hold toggles at E+5001.
    sw_k = 1'b1;
    for (int i = 0; i < 5001; i++) begin
      tick();
      if (int'(dut_k.cnt_q) > cnt_max) cnt_max = int'(dut_k.cnt_q);
    end
    check("k5000_not_yet", 32'(out_k), 0);
    tick();
    check("k5000_toggled", 32'(out_k), 1);
    check("k5000_cnt_after", 32'(dut_k.cnt_q), 0);
    check("k_cnt_never_over", 32'(cnt_max <= 4999), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
